// File: rtl/kulisch_pkg.sv
// Shared definitions for the Kulisch accumulation path (MMA side and drain side).
package kulisch_pkg;

    // Default accumulator geometry: two's complement, LSB weight 2^-FRAC_DEF.
    localparam int AWIDTH_DEF = 92;
    localparam int FRAC_DEF   = 48;

    // binary16 encoding constants.
    localparam int          BIAS    = 15;
    localparam int          EMIN    = -14;
    localparam int          EMAX    = 15;
    localparam int          MANT_W  = 10;
    localparam int          EXP_W   = 5;
    localparam logic [15:0] POS_INF = 16'h7C00;

    // Drain converter control states.
    typedef enum logic [2:0] {
        IDLE,
        ABS,
        SCAN,
        ROUND,
        OUT
    } state_t;

endpackage

// File: rtl/kulisch_lzc.sv
// Combinational leading-zero counter over a W-bit window, with an all-zero flag.
// count = W when the window is all zero.
module kulisch_lzc #(
    parameter int W = 8
) (
    input  logic [W-1:0]            din,
    output logic [$clog2(W+1)-1:0]  count,
    output logic                    zero
);

    localparam int CW = $clog2(W + 1);

    // Scan from LSB to MSB so the highest set bit makes the final assignment.
    always_comb begin
        // NOTE: count gets a default before the loop so no path leaves it unassigned (no latch).
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                count = CW'(W - 1 - i);
            end
        end
        zero = (din == '0);
    end

endmodule

// File: rtl/kulisch_to_fp16.sv
// Drain converter: wide two's-complement Kulisch accumulator word -> IEEE-754 binary16,
// round-to-nearest-even, gradual underflow, overflow to infinity.
// A coarse leading-zero scan shifts CHUNK bits per cycle, then one cycle of fine
// normalize + round. Optional status flags are enabled by defining KULISCH_TO_FP16_FLAGS_EN.
module kulisch_to_fp16
    import kulisch_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int CHUNK  = 8,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [AWIDTH-1:0] i_acc,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DWIDTH-1:0] o_fp16
`ifdef KULISCH_TO_FP16_FLAGS_EN
    ,
    output logic [2:0]        o_flags
`endif
);

    // Coarse scan never shifts further than this many chunks; the last window
    // then still contains the leading one of any nonzero magnitude.
    localparam int MAX_SHIFTS = (AWIDTH - 1) / CHUNK;
    localparam int SCW        = $clog2(MAX_SHIFTS + 1);
    localparam int CW         = $clog2(CHUNK + 1);
    // Bits of weight below 2^EMIN: everything a subnormal result can see.
    localparam int SUBW       = FRAC + EMIN;

    state_t             state_q, state_d;
    logic               run_q;
    logic               accept;
    logic               scan_more;

    logic [AWIDTH-1:0]  mag_q;
    logic [AWIDTH-1:0]  mag_abs;
    logic [SUBW-1:0]    sub_q;
    logic [SCW-1:0]     shift_q;
    logic               sign_q;

    logic [CW-1:0]      win_lz;
    logic               win_zero;

    int                 lz_total;
    int                 e_unb;
    logic [AWIDTH-2:0]  norm;
    logic [MANT_W-1:0]  mant;
    logic [EXP_W-1:0]   exp_f;
    logic               guard;
    logic               sticky;
    logic               inc;
    logic               is_sub;
    logic               is_inf_e;
    logic [14:0]        rounded;
    logic [DWIDTH-1:0]  res_fp16;

    // One LZC serves both the coarse all-zero test in SCAN and the fine count in ROUND.
    kulisch_lzc #(.W(CHUNK)) u_lzc (
        .din   (mag_q[AWIDTH-1 -: CHUNK]),
        .count (win_lz),
        .zero  (win_zero)
    );

    assign i_ready   = (state_q == IDLE) && run_q;
    assign o_valid   = (state_q == OUT);
    assign accept    = i_valid && i_ready;
    // Unary minus maps the most-negative word onto 2^(AWIDTH-1) exactly.
    assign mag_abs   = mag_q[AWIDTH-1] ? -mag_q : mag_q;
    assign scan_more = win_zero && (shift_q < SCW'(MAX_SHIFTS));

    // State register; run_q holds i_ready low until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ABS;
            ABS:     state_d = (mag_abs == '0) ? OUT : SCAN;
            SCAN:    if (!scan_more) state_d = ROUND;
            ROUND:   state_d = OUT;
            OUT:     if (o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: capture, absolute value, coarse left shift.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; every use is qualified by the FSM, which is reset.
        case (state_q)
            IDLE: begin
                if (accept) mag_q <= i_acc;
            end
            ABS: begin
                sign_q  <= mag_q[AWIDTH-1];
                mag_q   <= mag_abs;
                sub_q   <= mag_abs[SUBW-1:0];
                shift_q <= '0;
            end
            SCAN: begin
                if (scan_more) begin
                    mag_q   <= mag_q << CHUNK;
                    shift_q <= shift_q + SCW'(1);
                end
            end
            default: ;
        endcase
    end

    // Fine normalize, field extraction and RNE rounding for the ROUND cycle.
    always_comb begin
        lz_total = int'(shift_q) * CHUNK + int'(win_lz);
        e_unb    = (AWIDTH - 1 - FRAC) - lz_total;
        is_sub   = (e_unb < EMIN);
        is_inf_e = (e_unb > EMAX);

        // Drop the leading one: the fraction sits directly below it.
        norm   = (AWIDTH - 1)'(mag_q << win_lz);
        mant   = norm[AWIDTH-2 -: MANT_W];
        guard  = norm[AWIDTH-2-MANT_W];
        sticky = |norm[AWIDTH-3-MANT_W:0];
        exp_f  = EXP_W'(e_unb + BIAS);

        // Subnormals read fixed weights 2^-15..2^-24 from the unshifted magnitude.
        if (is_sub) begin
            mant   = sub_q[SUBW-1 -: MANT_W];
            guard  = sub_q[SUBW-1-MANT_W];
            sticky = |sub_q[SUBW-2-MANT_W:0];
            exp_f  = '0;
        end

        // Mantissa carry ripples into the exponent: subnormal->normal, max-normal->inf.
        inc     = guard & (sticky | mant[0]);
        rounded = {exp_f, mant} + 15'(inc);

        if (is_inf_e) begin
            res_fp16 = {sign_q, POS_INF[14:0]};
        end else begin
            res_fp16 = {sign_q, rounded};
        end
    end

`ifdef KULISCH_TO_FP16_FLAGS_EN
    logic [2:0] res_flags;

    // {overflow, underflow, inexact} for the value being rounded.
    always_comb begin
        res_flags[0] = guard | sticky;
        res_flags[1] = is_sub & (guard | sticky);
        res_flags[2] = is_inf_e | (rounded[14:10] == 5'h1F);
    end
`endif

    // Output result register, held through OUT until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_fp16  <= '0;
`ifdef KULISCH_TO_FP16_FLAGS_EN
            o_flags <= '0;
`endif
        end else if (state_q == ABS && mag_abs == '0) begin
            o_fp16  <= '0;
`ifdef KULISCH_TO_FP16_FLAGS_EN
            o_flags <= '0;
`endif
        end else if (state_q == ROUND) begin
            o_fp16  <= res_fp16;
`ifdef KULISCH_TO_FP16_FLAGS_EN
            o_flags <= res_flags;
`endif
        end
    end

endmodule

// File: tb/tb_kulisch_to_fp16.sv
// Self-checking bench for kulisch_to_fp16: scoreboard of expected fp16/latency/flags,
// backpressure hold and reset-abort scenarios. Flags are checked when
// KULISCH_TO_FP16_FLAGS_EN is defined.
module tb_kulisch_to_fp16;

    localparam int AW = 92;

    typedef struct {
        string       tag;
        logic [91:0] acc;
        logic [15:0] fp;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    typedef struct {
        string       tag;
        logic [15:0] fp;
        logic [2:0]  fl;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [AW-1:0] i_acc;
    logic          o_valid;
    logic          o_ready;
    logic [15:0]   o_fp16;
    logic [2:0]    o_flags;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   first_v  = 0;
    logic vprev    = 1'b0;
    exp_t sb[$];
    vec_t vecs[$];

    kulisch_to_fp16 dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_acc   (i_acc),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_fp16  (o_fp16)
`ifdef KULISCH_TO_FP16_FLAGS_EN
        ,
        .o_flags (o_flags)
`endif
    );

`ifndef KULISCH_TO_FP16_FLAGS_EN
    assign o_flags = 3'b000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: timestamp o_valid rise, compare against the scoreboard on handshake.
    always @(negedge clk) begin
        if (rst) begin
            vprev = 1'b0;
        end else begin
            if (o_valid && !vprev) first_v = cyc;
            vprev = o_valid;
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(o_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, "_fp16"}, 32'(o_fp16), 32'(e.fp));
                    check({e.tag, "_lat"}, 32'(first_v - e.acc_cyc), 32'(e.lat));
`ifdef KULISCH_TO_FP16_FLAGS_EN
                    check({e.tag, "_flags"}, 32'(o_flags), 32'(e.fl));
`endif
                end
            end
        end
    end

    // Drive one word until accepted; optionally record its expectation.
    task automatic issue(input vec_t v, input bit push);
        exp_t e;
        bit   done = 1'b0;
        i_valid = 1'b1;
        i_acc   = v.acc;
        for (int k = 0; k < 200 && !done; k++) begin
            if (i_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check({v.tag, "_accept_timeout"}, 32'd1, 32'd0);
        if (push && done) begin
            e.tag = v.tag; e.fp = v.fp; e.fl = v.fl; e.lat = v.lat; e.acc_cyc = cyc;
            sb.push_back(e);
        end
        i_valid = 1'b0;
        i_acc   = '0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    function automatic void add(input string tag, input logic [91:0] acc,
                                input logic [15:0] fp, input logic [2:0] fl, input int lat);
        vec_t v;
        v.tag = tag; v.acc = acc; v.fp = fp; v.fl = fl; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [91:0] one;
        logic [91:0] ones;
        vec_t        v;
        bit          seen;

        one  = 92'd1;
        ones = '1;

        // flags = {overflow, underflow, inexact}
        add("one",       one << 48,                               16'h3C00, 3'b000, 8);
        add("neg2p5",    -(92'd5 << 47),                          16'hC100, 3'b000, 8);
        add("zero",      92'd0,                                   16'h0000, 3'b000, 1);
        add("tie_even",  (one << 48) + (one << 37),               16'h3C00, 3'b001, 8);
        add("tie_up",    (one << 48) + (92'd3 << 37),             16'h3C02, 3'b001, 8);
        add("tie_stk",   (one << 48) + (one << 37) + one,         16'h3C01, 3'b001, 8);
        add("ovf_rnd",   92'd65520 << 48,                         16'h7C00, 3'b101, 6);
        add("max_norm",  92'd65504 << 48,                         16'h7BFF, 3'b000, 6);
        add("two15",     one << 63,                               16'h7800, 3'b000, 6);
        add("two16",     one << 64,                               16'h7C00, 3'b100, 6);
        add("most_neg",  one << 91,                               16'hFC00, 3'b100, 3);
        add("sub_min",   one << 24,                               16'h0001, 3'b000, 11);
        add("sub_tie",   one << 23,                               16'h0000, 3'b011, 11);
        add("sub_up",    92'd3 << 23,                             16'h0002, 3'b011, 11);
        add("sub2norm",  (one << 34) - (one << 23),               16'h0400, 3'b011, 10);
        add("min_norm",  one << 34,                               16'h0400, 3'b000, 10);
        add("neg_sub",   -(one << 24),                            16'h8001, 3'b000, 11);
        add("lsb",       one,                                     16'h0000, 3'b011, 14);
        add("neg_lsb",   ones,                                    16'h8000, 3'b011, 14);

        rst     = 1'b1;
        i_valid = 1'b0;
        i_acc   = '0;
        o_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_fp16",  32'(o_fp16),  32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_o_flags", 32'(o_flags), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(i_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(i_ready), 32'd1);

        // Main conversion table.
        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1);
            drain(vecs[i].tag);
        end

        // Backpressure: hold the result for 10 cycles.
        o_ready = 1'b0;
        v = vecs[1];
        v.tag = "bp";
        issue(v, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (o_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(o_valid), 32'd1);
            check("bp_hold_fp16",  32'(o_fp16),  32'hC100);
            check("bp_hold_ready", 32'(i_ready), 32'd0);
        end
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_fall", 32'(o_valid), 32'd0);
        check("bp_ready_back", 32'(i_ready), 32'd1);
        drain("bp");

        // Reset during SCAN aborts the conversion.
        v = vecs[17];
        v.tag = "abort";
        issue(v, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_rst_valid", 32'(o_valid), 32'd0);
        check("abort_rst_fp16",  32'(o_fp16),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        check("abort_fp16_zero", 32'(o_fp16), 32'd0);
        check("abort_ready",     32'(i_ready), 32'd1);

        v = vecs[0];
        v.tag = "post_abort";
        issue(v, 1'b1);
        drain("post_abort");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
